aes_round_controller_param: RTL

- Parametrised successor of the fixed AES-128 round-based controller for the NullFresh masked AES datapath.
- Generates all per-cycle datapath strobes: ShiftRows, MixColumns, key-schedule S-box, mux selects and Rcon.
- Adds a start/busy handshake, an explicit FSM with an idle state, and a configurable round count (NR=10/12/14) and per-round cycle budget.
- Sits between the testbench/top-level wrapper and the shared-Sbox serial datapath; one controller instance per encryption core.

---
 rtl/aes_round_controller_param.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/aes_round_controller_param.sv
// Round/phase sequencer for the serial masked AES datapath: an IDLE/INIT/RUN/FINAL
// FSM whose registered round and phase counters are decoded into the per-cycle strobes.
module aes_round_controller_param #(
    parameter int NR        = 10,
    parameter int FIRST_CYC = 20,
    parameter int RND_CYC   = 23,
    parameter int MC_STRIDE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    output logic       busy_o,
    output logic [3:0] round_o,
    output logic       key_sched_en,
    output logic       show_rcon,
    output logic       do_sr,
    output logic       do_mc,
    output logic       state_hold,
    output logic       key_hold,
    output logic       do_key_sbox,
    output logic       first_col_shift,
    output logic       done,
    output logic       ct_valid,
    output logic       output_sel,
    output logic [1:0] key_in_sel,
    output logic [1:0] sbox_in_sel,
    output logic [7:0] rcon
);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_FINAL} state_e;

    localparam logic [5:0] INIT_LAST  = 6'(FIRST_CYC - 1);
    localparam logic [5:0] INIT_KSBOX = 6'(FIRST_CYC - 4);
    localparam logic [5:0] RND_LAST   = 6'(RND_CYC - 1);
    localparam logic [5:0] RND_KSBOX  = 6'(RND_CYC - 4);
    localparam logic [5:0] SBOX_HI    = 6'(RND_CYC - 5);
    localparam logic [5:0] FINAL_LAST = 6'd18;
    localparam logic [3:0] NR_RC      = 4'(NR);
    localparam logic [7:0] RCON_INIT  = 8'h01;

    state_e     state_q, state_d;
    logic [5:0] pc_q, pc_d;
    logic [3:0] rc_q, rc_d;
    logic [7:0] rcon_q, rcon_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rc_d    = rc_q;
        rcon_d  = rcon_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_INIT;
                    pc_d    = '0;
                    rc_d    = '0;
                    rcon_d  = RCON_INIT;
                end
            end
            S_INIT: begin
                if (pc_q == INIT_LAST) begin
                    pc_d    = '0;
                    rc_d    = 4'd1;
                    state_d = (NR_RC == 4'd1) ? S_FINAL : S_RUN;
                end else begin
                    pc_d = pc_q + 6'd1;
                end
            end
            S_RUN: begin
                if (pc_q == RND_LAST) begin
                    pc_d   = '0;
                    rc_d   = rc_q + 4'd1;
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
                    if ((rc_q + 4'd1) == NR_RC) state_d = S_FINAL;
                end else begin
                    pc_d = pc_q + 6'd1;
                end
            end
            S_FINAL: begin
                // Counters and Rcon return to their reset values so IDLE looks like reset.
                if (pc_q == FINAL_LAST) begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                    rc_d    = '0;
                    rcon_d  = RCON_INIT;
                end else begin
                    pc_d = pc_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            rc_q    <= '0;
            rcon_q  <= RCON_INIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rc_q    <= rc_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        busy_o          = (state_q != S_IDLE);
        round_o         = rc_q;
        rcon            = rcon_q;
        key_sched_en    = 1'b0;
        show_rcon       = 1'b0;
        do_sr           = 1'b0;
        do_mc           = 1'b0;
        state_hold      = 1'b1;
        key_hold        = 1'b1;
        do_key_sbox     = 1'b0;
        first_col_shift = 1'b0;
        done            = 1'b0;
        ct_valid        = 1'b0;
        output_sel      = 1'b1;
        key_in_sel      = 2'd0;
        sbox_in_sel     = 2'd0;
        case (state_q)
            S_INIT: begin
                if (pc_q >= INIT_KSBOX) begin
                    sbox_in_sel = 2'd1;
                    do_key_sbox = 1'b1;
                end
            end
            S_RUN, S_FINAL: begin
                case (pc_q)
                    6'd0: key_hold = 1'b0;
                    6'd1: begin
                        do_sr    = 1'b1;
                        key_hold = 1'b0;
                    end
                    6'd2: begin
                        key_sched_en    = 1'b1;
                        state_hold      = 1'b0;
                        first_col_shift = 1'b1;
                    end
                    6'd3: begin
                        show_rcon    = 1'b1;
                        key_sched_en = 1'b1;
                    end
                    6'd4, 6'd5: key_sched_en = 1'b1;
                    default: ;
                endcase
                // Round 1 still takes the freshly loaded key for its first phases.
                if (rc_q == 4'd1 && pc_q < 6'd3)      key_in_sel = 2'd0;
                else if (pc_q >= 6'd3 && pc_q <= 6'd6) key_in_sel = 2'd1;
                else                                   key_in_sel = 2'd2;
                if (pc_q < 6'd3 || pc_q > SBOX_HI) sbox_in_sel = 2'd1;
                else if (pc_q < 6'd7)              sbox_in_sel = 2'd2;
                else                               sbox_in_sel = 2'd3;
                if (state_q == S_RUN) begin
                    for (int k = 0; k < 4; k++) begin
                        if (pc_q == 6'(3 + k * MC_STRIDE)) do_mc = 1'b1;
                    end
                    if (pc_q >= RND_KSBOX) do_key_sbox = 1'b1;
                end else begin
                    if (pc_q >= 6'd3 && pc_q <= 6'd6)  output_sel = 1'b0;
                    if (pc_q >= 6'd3 && pc_q <= 6'd18) done       = 1'b1;
                    if (pc_q == 6'd4)                  ct_valid   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
